// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: per-slot dead time, PWM dimming, per-digit blink
// and frame-level snapshots so a frame never shows a mix of old and new digit values.
module seg_scan_driver #(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV       = 65536,
    parameter int DEAD_CYC       = 64,
    parameter int BLINK_DIV      = 25000000,
    parameter int BRIGHT_W       = 4,
    parameter int HEX_EN         = 0,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 1,
    localparam int CNT_W         = $clog2(NUM_DIGITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NUM_DIGITS*4-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [CNT_W-1:0]        digit_count,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [6:0]              led_segment,
    output logic                    led_dp,
    output logic [NUM_DIGITS-1:0]   dis_sel,
    output logic                    frame_start
);
    localparam int   IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int   SLOT_W  = $clog2(SCAN_DIV);
    localparam int   BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic SEG_OFF = (SEG_ACTIVE_LOW != 0);
    localparam logic SEL_OFF = (SEL_ACTIVE_LOW != 0);

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    state_t                  state_q, state_d;
    logic [SLOT_W-1:0]       slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
    logic [BRIGHT_W-1:0]     pwm_cnt_q, pwm_cnt_d;
    logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic [NUM_DIGITS-1:0]   mask_prev_q;
    logic [NUM_DIGITS*4-1:0] digits_snap_q, digits_snap_d;
    logic [NUM_DIGITS-1:0]   dp_snap_q, dp_snap_d;
    logic [NUM_DIGITS-1:0]   blink_snap_q, blink_snap_d;
    logic [CNT_W-1:0]        count_snap_q, count_snap_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic                    fs_q, fs_d;

    logic                    slot_wrap, frame_begin, lit, pwm_on;
    logic [CNT_W-1:0]        eff_count;
    logic [3:0]              cur_val;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = (HEX_EN != 0) ? 7'h77 : 7'h00;
            4'hB: s = (HEX_EN != 0) ? 7'h7C : 7'h00;
            4'hC: s = (HEX_EN != 0) ? 7'h39 : 7'h00;
            4'hD: s = (HEX_EN != 0) ? 7'h5E : 7'h00;
            4'hE: s = (HEX_EN != 0) ? 7'h79 : 7'h00;
            default: s = (HEX_EN != 0) ? 7'h71 : 7'h00;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_wrap   = (slot_cnt_q == SLOT_W'(SCAN_DIV - 1));
        frame_begin = (slot_cnt_q == '0) && (digit_idx_q == '0);
        eff_count   = (digit_count == '0 || digit_count > CNT_W'(NUM_DIGITS))
                      ? CNT_W'(NUM_DIGITS) : digit_count;

        slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        if (slot_wrap) begin
            if (CNT_W'(digit_idx_q) == count_snap_q - CNT_W'(1))
                digit_idx_d = '0;
            else
                digit_idx_d = digit_idx_q + 1'b1;
        end
        pwm_cnt_d = pwm_cnt_q + 1'b1;

        // A freshly enabled blink starts in the visible half so the edit is seen at once.
        blink_cnt_d   = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) ? '0 : blink_cnt_q + 1'b1;
        blink_phase_d = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) ? ~blink_phase_q : blink_phase_q;
        if ((|blink_mask) && !(|mask_prev_q)) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end

        digits_snap_d = digits_snap_q;
        dp_snap_d     = dp_snap_q;
        blink_snap_d  = blink_snap_q;
        count_snap_d  = count_snap_q;
        if (frame_begin) begin
            digits_snap_d = digits_in;
            dp_snap_d     = dp_in;
            blink_snap_d  = blink_mask;
            count_snap_d  = eff_count;
        end

        state_d = state_q;
        case (state_q)
            ST_BLANK: if (slot_cnt_q == SLOT_W'(DEAD_CYC - 1)) state_d = ST_DRIVE;
            default:  if (slot_wrap) state_d = ST_BLANK;
        endcase

        pwm_on  = (pwm_cnt_q < brightness) || (&brightness);
        lit     = (state_q == ST_DRIVE) && en && pwm_on
                  && !(blink_snap_q[digit_idx_q] && blink_phase_q);
        cur_val = digits_snap_q[{digit_idx_q, 2'b00} +: 4];

        // Off level XOR lit-high pattern gives the pin polarity in one step.
        seg_d = {7{SEG_OFF}};
        dp_d  = SEG_OFF;
        sel_d = {NUM_DIGITS{SEL_OFF}};
        if (lit) begin
            seg_d = decode(cur_val) ^ {7{SEG_OFF}};
            dp_d  = dp_snap_q[digit_idx_q] ^ SEG_OFF;
            sel_d = (NUM_DIGITS'(1) << digit_idx_q) ^ {NUM_DIGITS{SEL_OFF}};
        end
        fs_d = frame_begin;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_BLANK;
            slot_cnt_q    <= '0;
            digit_idx_q   <= '0;
            pwm_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            mask_prev_q   <= '0;
            digits_snap_q <= '0;
            dp_snap_q     <= '0;
            blink_snap_q  <= '0;
            count_snap_q  <= CNT_W'(NUM_DIGITS);
            seg_q         <= {7{SEG_OFF}};
            dp_q          <= SEG_OFF;
            sel_q         <= {NUM_DIGITS{SEL_OFF}};
            fs_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_cnt_q    <= slot_cnt_d;
            digit_idx_q   <= digit_idx_d;
            pwm_cnt_q     <= pwm_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            mask_prev_q   <= blink_mask;
            digits_snap_q <= digits_snap_d;
            dp_snap_q     <= dp_snap_d;
            blink_snap_q  <= blink_snap_d;
            count_snap_q  <= count_snap_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            sel_q         <= sel_d;
            fs_q          <= fs_d;
        end
    end

    assign led_segment = seg_q;
    assign led_dp      = dp_q;
    assign dis_sel     = sel_q;
    assign frame_start = fs_q;
endmodule
